time_scale_timer: RTL

Multi-channel, synthesizable one-shot timer that accepts delay requests in a coarse time unit, rescales them to clock ticks by a power of ten plus a fixed offset, and emits a single-cycle fire pulse per channel when the scaled delay expires. It is the hardware counterpart of the unit-conversion helpers used in the simulation flow. It generalises a single fixed-unit delay to N independent channels with configurable scale, offset and width. It sits between a command source and any logic needing timed events.

---
 rtl/time_scale_timer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/time_scale_timer.sv
// Multi-channel one-shot timer: delay x 10^SCALE_EXP + OFFSET ticks.
// Optional cancel ports when TIME_SCALE_CANCEL_EN is defined.
module time_scale_timer #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 32,
  parameter int TICK_WIDTH = 48,
  parameter int SCALE_EXP  = 3,
  parameter int OFFSET     = 0,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CW-1:0]       req_chan,
  input  logic [WIDTH-1:0]    req_delay,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] fire,
  output logic                sat
`ifdef TIME_SCALE_CANCEL_EN
  ,
  input  logic                cancel_valid,
  input  logic [CW-1:0]       cancel_chan
`endif
);

  localparam int AW = TICK_WIDTH + 4;
  localparam int SW = AW + 1;
  localparam logic [SW-1:0] OFF_X = SW'(OFFSET);
  localparam logic [2:0] LAST = 3'(SCALE_EXP - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCALE = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [2:0]    step_q, step_d;
  logic [CW-1:0] chan_q, chan_d;
  logic          sat_q, sat_d;

  logic [TICK_WIDTH-1:0] cnt_q [CHANNELS];
  logic [TICK_WIDTH-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0]   busy_q, busy_d;
  logic [CHANNELS-1:0]   fire_q, fire_d;

  logic [AW-1:0]         acc_x10;
  logic [SW-1:0]         sum;
  logic                  load_sat;
  logic [TICK_WIDTH-1:0] load_val;
  logic [CHANNELS-1:0]   load_v;
  logic [CHANNELS-1:0]   kill_v;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = busy_q;
  assign fire      = fire_q;
  assign sat       = sat_q;

  // Multiply by ten as x8 + x2; sum with offset and saturate at tick max.
  always_comb begin
    acc_x10  = (acc_q << 3) + (acc_q << 1);
    sum      = {1'b0, acc_q} + OFF_X;
    load_sat = ovf_q | (|sum[SW-1:TICK_WIDTH]);
    load_val = load_sat ? '1 : sum[TICK_WIDTH-1:0];
  end

  // Converter FSM: IDLE -> SCALE x SCALE_EXP -> LOAD -> IDLE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    step_d  = step_q;
    chan_d  = chan_q;
    sat_d   = sat_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          acc_d   = AW'(req_delay);
          chan_d  = req_chan;
          ovf_d   = 1'b0;
          step_d  = 3'd0;
          state_d = (SCALE_EXP == 0) ? S_LOAD : S_SCALE;
        end
      end
      S_SCALE: begin
        acc_d  = acc_x10;
        ovf_d  = ovf_q | (|acc_x10[AW-1:TICK_WIDTH]);
        step_d = step_q + 3'd1;
        if (step_q == LAST) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_IDLE;
        if (load_sat) sat_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-channel count: load beats cancel beats expiry.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    fire_d = '0;
    load_v = '0;
    kill_v = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      load_v[c] = (state_q == S_LOAD) && (chan_q == CW'(c));
`ifdef TIME_SCALE_CANCEL_EN
      kill_v[c] = cancel_valid && (cancel_chan == CW'(c));
`endif
      if (load_v[c]) begin
        cnt_d[c]  = load_val;
        busy_d[c] = 1'b1;
      end else if (kill_v[c]) begin
        busy_d[c] = 1'b0;
      end else if (busy_q[c]) begin
        if (cnt_q[c] == '0) begin
          fire_d[c] = 1'b1;
          busy_d[c] = 1'b0;
        end else begin
          cnt_d[c] = cnt_q[c] - TICK_WIDTH'(1);
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      step_q  <= 3'd0;
      chan_q  <= '0;
      sat_q   <= 1'b0;
      busy_q  <= '0;
      fire_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      step_q  <= step_d;
      chan_q  <= chan_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      fire_q  <= fire_d;
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= cnt_d[c];
    end
  end

endmodule
